// File: rtl/alu_arbitro_pkg.sv
// alu_arbitro_pkg: ALU select codes, sequencer states and select legality helper
package alu_arbitro_pkg;
   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
   function automatic logic sel_legal(input logic [3:0] s);
      return s inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
   endfunction
endpackage

// File: rtl/alu_arbitro_rr.sv
// alu_arbitro_rr: two-input round-robin picker, the port other than the last grant wins a tie
module alu_arbitro_rr (
   input  logic [1:0] i_valid,
   input  logic       i_last,
   output logic       o_grant,
   output logic       o_any
);
   assign o_any   = |i_valid;
   assign o_grant = &i_valid ? ~i_last : i_valid[1];
endmodule

// File: rtl/alu_arbitro.sv
// alu_arbitro: round-robin arbiter and sequencer sharing one combinational ALU between two ports
module alu_arbitro
   import alu_arbitro_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_op1,
   input  logic [WIDTH-1:0] req0_op2,
   input  logic [3:0]       req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_op1,
   input  logic [WIDTH-1:0] req1_op2,
   input  logic [3:0]       req1_sel,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_resultado,
   output logic             rsp0_zf,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_resultado,
   output logic             rsp1_zf,
   output logic             rsp1_err,
   output logic [WIDTH-1:0] alu_op1,
   output logic [WIDTH-1:0] alu_op2,
   output logic [3:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_resultado,
   input  logic             alu_zf
);
   state_t           r_state, w_next;
   logic             r_last, r_gnt, r_zf, r_err;
   logic [WIDTH-1:0] r_op1, r_op2, r_res;
   logic [3:0]       r_sel;
   logic             w_gnt, w_any, w_acc, w_legal;
   alu_arbitro_rr u_rr (
      .i_valid ({req1_valid, req0_valid}),
      .i_last  (r_last),
      .o_grant (w_gnt),
      .o_any   (w_any)
   );
   always_comb begin
      w_next = r_state;
      w_acc  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_acc  = w_any;
            w_next = w_any ? ST_EXEC : ST_IDLE;
         end
         ST_EXEC: w_next = ST_RESP;
         ST_RESP: w_next = (r_gnt ? rsp1_ready : rsp0_ready) ? ST_IDLE : ST_RESP;
         default: w_next = ST_IDLE;
      endcase
   end
   assign w_legal = sel_legal(r_sel);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_gnt   <= 1'b0;
         r_op1   <= '0;
         r_op2   <= '0;
         r_sel   <= '0;
         r_res   <= '0;
         r_zf    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_last <= w_gnt;
            r_gnt  <= w_gnt;
            r_op1  <= w_gnt ? req1_op1 : req0_op1;
            r_op2  <= w_gnt ? req1_op2 : req0_op2;
            r_sel  <= w_gnt ? req1_sel : req0_sel;
         end
         // illegal selects discard whatever the ALU produced
         if (r_state == ST_EXEC) begin
            r_res <= w_legal ? alu_resultado : '0;
            r_zf  <= w_legal & alu_zf;
            r_err <= ~w_legal;
         end
      end
   end
   assign req0_ready     = w_acc & ~w_gnt;
   assign req1_ready     = w_acc & w_gnt;
   assign rsp0_valid     = (r_state == ST_RESP) & ~r_gnt;
   assign rsp1_valid     = (r_state == ST_RESP) & r_gnt;
   assign rsp0_resultado = r_res;
   assign rsp1_resultado = r_res;
   assign rsp0_zf        = r_zf;
   assign rsp1_zf        = r_zf;
   assign rsp0_err       = r_err;
   assign rsp1_err       = r_err;
   assign alu_op1        = r_op1;
   assign alu_op2        = r_op2;
   assign alu_sel        = r_sel;
endmodule

// File: tb/tb_alu_arbitro.sv
// tb_alu_arbitro: randomized scoreboard bench with a behavioural ALU/arbiter reference
module tb_alu_arbitro;
   localparam int W = 32;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic         pv [2];
   logic         rr [2];
   logic [W-1:0] pa [2];
   logic [W-1:0] pb [2];
   logic [3:0]   ps [2];
   logic [3:0]   lg [6];
   logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic         rsp0_zf, rsp1_zf, rsp0_err, rsp1_err, alu_zf;
   logic [W-1:0] rsp0_resultado, rsp1_resultado, alu_op1, alu_op2, alu_resultado;
   logic [3:0]   alu_sel;
   logic [33:0]  w_alu;
   int total = 0;
   int bad = 0;
   alu_arbitro #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(pv[0]), .req0_ready(req0_ready), .req0_op1(pa[0]), .req0_op2(pb[0]), .req0_sel(ps[0]),
      .req1_valid(pv[1]), .req1_ready(req1_ready), .req1_op1(pa[1]), .req1_op2(pb[1]), .req1_sel(ps[1]),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_resultado(rsp0_resultado), .rsp0_zf(rsp0_zf), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_resultado(rsp1_resultado), .rsp1_zf(rsp1_zf), .rsp1_err(rsp1_err),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel), .alu_resultado(alu_resultado), .alu_zf(alu_zf)
   );
   // {err, zf, result} a requester should see for one operation
   function automatic logic [33:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
      logic [W-1:0] r;
      logic         e;
      e = 1'b0;
      case (s)
         4'd0:    r = a & b;
         4'd1:    r = a | b;
         4'd2:    r = a + b;
         4'd6:    r = a - b;
         4'd7:    r = {31'd0, $signed(a) < $signed(b)};
         4'd12:   r = ~(a | b);
         default: begin r = '0; e = 1'b1; end
      endcase
      return {e, (r == '0) && !e, r};
   endfunction
   // external ALU: illegal selects produce junk the DUT must discard
   always_comb begin
      w_alu         = ref_alu(alu_op1, alu_op2, alu_sel);
      alu_resultado = w_alu[33] ? (alu_op1 ^ 32'h5A5A_0001) : w_alu[31:0];
      alu_zf        = w_alu[33] | w_alu[32];
   end
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
      end
   endtask
   logic         busy = 1'b0, bport = 1'b0, last = 1'b1, after_rst = 1'b0;
   int           cyc = 0, tacc = 0;
   logic [W-1:0] lop1 = '0, lop2 = '0;
   logic [3:0]   lsel = '0;
   logic [33:0]  prev = '0;
   logic [33:0]  sb0 [$];
   logic [33:0]  sb1 [$];
   always @(negedge clk) begin
      logic [1:0]  v, r, rv;
      logic [33:0] act, e;
      logic        g, ga;
      cyc++;
      if (rst) begin
         sb0.delete();
         sb1.delete();
         busy = 1'b0; last = 1'b1; after_rst = 1'b1;
         lop1 = '0; lop2 = '0; lsel = '0;
      end else begin
         v  = {pv[1], pv[0]};
         r  = {req1_ready, req0_ready};
         rv = {rsp1_valid, rsp0_valid};
         if (after_rst) begin
            chk("rst_rsp0", 64'({rsp0_resultado, rsp0_zf, rsp0_err}), 64'd0);
            chk("rst_rsp1", 64'({rsp1_resultado, rsp1_zf, rsp1_err}), 64'd0);
            after_rst = 1'b0;
         end
         chk("alu_op1", 64'(alu_op1), 64'(lop1));
         chk("alu_op2", 64'(alu_op2), 64'(lop2));
         chk("alu_sel", 64'(alu_sel), 64'(lsel));
         chk("ready_no_valid", 64'(r & ~v), 64'd0);
         if (!busy) begin
            chk("rsp_idle", 64'(rv), 64'd0);
            g = (v == 2'b11) ? ~last : v[1];
            chk("grant", 64'(r), (v == 2'b00) ? 64'd0 : (g ? 64'd2 : 64'd1));
            if (|(r & v)) begin
               ga = r[1] & v[1];
               e = ref_alu(pa[ga], pb[ga], ps[ga]);
               if (ga) sb1.push_back(e); else sb0.push_back(e);
               busy = 1'b1; bport = ga; tacc = cyc; last = ga;
               lop1 = pa[ga]; lop2 = pb[ga]; lsel = ps[ga];
            end
         end else begin
            chk("ready_busy", 64'(r), 64'd0);
            chk("rsp_valid", 64'(rv), (cyc >= tacc + 2) ? (bport ? 64'd2 : 64'd1) : 64'd0);
            if (cyc >= tacc + 2) begin
               act = bport ? {rsp1_err, rsp1_zf, rsp1_resultado} : {rsp0_err, rsp0_zf, rsp0_resultado};
               if (cyc > tacc + 2) chk("rsp_stable", 64'(act), 64'(prev));
               prev = act;
               if (rr[bport]) begin
                  e = bport ? sb1.pop_front() : sb0.pop_front();
                  chk(bport ? "rsp1_data" : "rsp0_data", 64'(act), 64'(e));
                  busy = 1'b0;
               end
            end
         end
      end
   end
   task automatic step();
      logic a0, a1;
      @(negedge clk);
      a0 = pv[0] && req0_ready && !rst;
      a1 = pv[1] && req1_ready && !rst;
      @(posedge clk);
      #1;
      if (a0) pv[0] = 1'b0;
      if (a1) pv[1] = 1'b0;
   endtask
   task automatic load(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
      pa[p] = a; pb[p] = b; ps[p] = s; pv[p] = 1'b1;
   endtask
   task automatic wait_acc(input int p, output int n);
      n = 0;
      while (pv[p] && n < 100) begin step(); n++; end
      chk("accept_timeout", 64'(pv[p]), 64'd0);
   endtask
   task automatic drain();
      int n;
      n = 0;
      while ((pv[0] || pv[1] || busy) && n < 300) begin step(); n++; end
      chk("drain_timeout", 64'(pv[0] || pv[1] || busy), 64'd0);
   endtask
   initial begin
      int n;
      lg = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
      for (int p = 0; p < 2; p++) begin
         pv[p] = 1'b0; rr[p] = 1'b0; pa[p] = '0; pb[p] = '0; ps[p] = '0;
      end
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      rr[0] = 1'b1; rr[1] = 1'b1;
      load(0, 32'd5, 32'd7, 4'd2);
      drain();
      rst = 1'b1; step(); rst = 1'b0;
      load(0, 32'd9, 32'd9, 4'd6);
      load(1, 32'hF0, 32'h0F, 4'd1);
      drain();
      load(0, $urandom, $urandom, 4'd2);
      load(1, $urandom, $urandom, 4'd0);
      drain();
      load(1, 32'd1, 32'd1, 4'd3);
      drain();
      rr[0] = 1'b0;
      load(0, 32'd100, 32'd58, 4'd6);
      load(1, 32'd3, 32'd4, 4'd2);
      repeat (12) step();
      rr[0] = 1'b1;
      drain();
      load(0, 32'd7, 32'd3, 4'd7);
      wait_acc(0, n);
      rst = 1'b1; step(); rst = 1'b0;
      load(0, 32'd1, 32'd2, 4'd2);
      load(1, 32'd3, 32'd4, 4'd2);
      drain();
      load(0, 32'd0, 32'd0, 4'd12);
      wait_acc(0, n);
      repeat (4) begin
         load(0, 32'd0, 32'd0, 4'd12);
         wait_acc(0, n);
         chk("issue_interval", 64'(n), 64'd3);
      end
      drain();
      for (int i = 0; i < 1500; i++) begin
         for (int p = 0; p < 2; p++)
            if (!pv[p] && $urandom_range(2) == 0)
               load(p, $urandom_range(1) ? $urandom : $urandom_range(3),
                       $urandom_range(1) ? $urandom : $urandom_range(3),
                       ($urandom_range(4) == 0) ? 4'($urandom) : lg[$urandom_range(5)]);
         rr[0] = $urandom_range(3) != 0;
         rr[1] = $urandom_range(3) != 0;
         step();
      end
      rr[0] = 1'b1; rr[1] = 1'b1;
      drain();
      chk("scoreboard_empty", 64'(sb0.size() + sb1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_arbitro.md
# alu_arbitro

Two-port arbiter and sequencer for the shared 32-bit ALU. Two requesters (e.g. main datapath and branch/address unit) each issue operand pairs plus a 4-bit operation select. The block grants the ALU round-robin, registers operands, captures result and zero flag, and returns them on a per-port response handshake. It sits between the requesters and the single ALU instance, which stays combinational and is instantiated alongside it.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present on port i
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op1, req0_op2 / req1_op1, req1_op2  in  WIDTH  operands
- req0_sel / req1_sel  in  4  operation select
- rsp0_valid / rsp1_valid  out  1  response present on port i
- rsp0_ready / rsp1_ready  in  1  response consumed
- rsp0_resultado / rsp1_resultado  out  WIDTH  result
- rsp0_zf / rsp1_zf  out  1  zero flag
- rsp0_err / rsp1_err  out  1  illegal select
- alu_op1, alu_op2  out  WIDTH  to ALU
- alu_sel  out  4  to ALU
- alu_resultado  in  WIDTH  from ALU
- alu_zf  in  1  from ALU

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any req_valid, select grant port; that port's req_ready=1 combinationally (only when its valid=1, state IDLE, and it is the grant). Latch op1/op2/sel and grant id; go EXEC. Otherwise stay.
- Round-robin: a 1-bit pointer `last` records the last granted port; reset value 1, so port 0 wins the first tie. Sole requester always wins. Both valid: the port != last wins. `last` updates on each grant.
- EXEC: latched operands/sel drive alu_op1/op2/sel; at cycle end capture alu_resultado and alu_zf into response registers; go RESP.
- Legal sel: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR. Any other sel: ALU output ignored, captured result=0, zf=0, err=1.
- RESP: rsp_valid=1 on granted port only; result/zf/err stable until handshake. On rsp_ready=1, go IDLE. No new request accepted in RESP.
- alu_op1/op2/sel hold the latched values in all states (0 after reset until first grant).
- Arithmetic is the ALU's; this block adds no width extension or flag logic except the illegal-sel override.

## Timing
- Reset values: all req_ready=0, rsp_valid=0, rsp_resultado=0, rsp_zf=0, rsp_err=0, alu_op1/op2=0, alu_sel=0, state IDLE, last=1.
- Accept at edge t (valid&&ready high in cycle t); EXEC in t+1; rsp_valid high from cycle t+2.
- Min issue interval 3 cycles (accept, exec, resp with immediate ready).
- rsp_ready held low: RESP held indefinitely; other port starves, its req_ready stays 0.
- req_valid dropping before acceptance: no grant, no state change.
- rsp_ready on a non-granted port: ignored.
- rst in any state: next cycle fully in reset values, in-flight op discarded, no response issued.

## Structure
- Shared include alu_defs.vh: sel codes (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12), state encodings.
- One sub-module natural: rr_arbitro2 (2-input round-robin picker: valids + last -> grant id + any_valid).
- ALU itself instantiated by parent, not inside this block.

## Test plan
- Reset, then req0 ADD 5+7 alone -> req0_ready in same cycle, rsp0_valid 2 cycles later, resultado=12, zf=0, err=0.
- Both valid after reset: req0 SUB 9-9, req1 OR 0xF0|0x0F -> port 0 first (resultado=0, zf=1), then port 1 (0xFF); then both again -> port 0 wins (last=1).
- req1 sel=3 op1=1 op2=1 -> rsp1 resultado=0, zf=0, err=1.
- rsp0_ready held low 10 cycles with req1 valid -> rsp0 values stable, req1_ready 0 throughout; release -> IDLE, req1 granted next cycle.
- rst asserted in EXEC -> no rsp_valid, all outputs at reset values next cycle, next tie grants port 0.
- Back-to-back single requester NOR 0,0 with rsp_ready tied high -> one accept every 3 cycles, resultado=0xFFFFFFFF, zf=0.
